// File: rtl/uart_sync_edge.sv
// Two-flop synchronizer for the raw rxd pad with a registered previous value.
// Flops reset high so a line that idles high does not produce a falling edge out of reset.
module uart_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain plus one-cycle history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign sync = sync_r;
  assign fall = prev_r & ~sync_r;

endmodule

// File: rtl/uart_autobaud.sv
// Auto-baud controller: measures a 0x55 sync character on rxd and drives the
// shared UART prescale (clock cycles per bit / 8) once the measurement is accepted.
module uart_autobaud #(
  parameter int          COUNT_WIDTH      = 22,
  parameter int          IDLE_CYCLES      = 1024,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd1,
  parameter logic [15:0] MIN_PRESCALE     = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  input  logic        arm,
  output logic [15:0] prescale,
  output logic        locked,
  output logic        busy,
  output logic        error
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_IDLE  = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_FINISH     = 3'd4,
    ST_ERROR      = 3'd5
  } state_t;

  // 0x55 LSB-first: falls at bit times 0,2,4,6,8 -> the edge_idx==3 fall closes the 4th interval
  localparam logic [1:0]             LAST_EDGE = 2'd3;
  localparam int                     IDLE_W    = $clog2(IDLE_CYCLES) + 1;
  localparam int                     PW        = (COUNT_WIDTH + 1 > 17) ? COUNT_WIDTH + 1 : 17;
  localparam logic [IDLE_W-1:0]      IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

  state_t                 state_r;
  state_t                 state_s;
  logic                   sync_s;
  logic                   fall_s;
  logic [IDLE_W-1:0]      idle_cnt_r;
  logic [COUNT_WIDTH-1:0] int_cnt_r;
  logic [COUNT_WIDTH-1:0] total_r;
  logic [COUNT_WIDTH-1:0] t0_r;
  logic [1:0]             edge_idx_r;
  logic [15:0]            prescale_r;
  logic                   locked_r;
  logic                   busy_r;
  logic                   error_r;
  logic [COUNT_WIDTH:0]   diff_s;
  logic                   within_s;
  logic                   timeout_s;
  logic                   range_bad_s;
  logic                   commit_s;
  logic                   final_edge_s;
  logic [PW-1:0]          sum_s;
  logic [PW-1:0]          p_s;

  uart_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (rxd),
    .sync (sync_s),
    .fall (fall_s)
  );

  // Tolerance check, timeout detect and rounded divide-by-64 of the 8-bit total
  always_comb begin
    if (int_cnt_r >= t0_r) begin
      diff_s = {1'b0, int_cnt_r - t0_r};
    end else begin
      diff_s = {1'b0, t0_r - int_cnt_r};
    end
    within_s    = (diff_s <= {3'b000, t0_r[COUNT_WIDTH-1:2]});
    timeout_s   = (int_cnt_r == CNT_MAX) || (total_r == CNT_MAX);
    sum_s       = {{(PW-COUNT_WIDTH){1'b0}}, total_r} + PW'(6'd32);
    p_s         = sum_s >> 3'd6;
    range_bad_s = (p_s > {{(PW-16){1'b0}}, 16'hFFFF}) ||
                  (p_s < {{(PW-16){1'b0}}, MIN_PRESCALE});
  end

  // Next-state logic; arm overrides every state including a pending FINISH
  always_comb begin
    state_s      = state_r;
    final_edge_s = 1'b0;
    commit_s     = 1'b0;
    if (arm) begin
      state_s = ST_WAIT_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_s = ST_IDLE;
        ST_WAIT_IDLE: begin
          if (sync_s && (idle_cnt_r == IDLE_LAST)) state_s = ST_WAIT_START;
          else                                      state_s = ST_WAIT_IDLE;
        end
        ST_WAIT_START: begin
          if (fall_s) state_s = ST_MEASURE;
          else        state_s = ST_WAIT_START;
        end
        ST_MEASURE: begin
          if (timeout_s) begin
            state_s = ST_ERROR;
          end else if (fall_s && (edge_idx_r != 2'd0)) begin
            if (!within_s) begin
              state_s = ST_ERROR;
            end else if (edge_idx_r == LAST_EDGE) begin
              state_s      = ST_FINISH;
              final_edge_s = 1'b1;
            end else begin
              state_s = ST_MEASURE;
            end
          end else begin
            state_s = ST_MEASURE;
          end
        end
        ST_FINISH: begin
          if (range_bad_s) begin
            state_s = ST_ERROR;
          end else begin
            state_s  = ST_IDLE;
            commit_s = 1'b1;
          end
        end
        ST_ERROR: state_s = ST_WAIT_IDLE;
        default:  state_s = ST_WAIT_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_WAIT_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Idle, interval and total counters; total freezes on the accepting edge so it spans exactly 8 bits
  always_ff @(posedge clk) begin
    if (rst || arm) begin
      idle_cnt_r <= '0;
      int_cnt_r  <= '0;
      total_r    <= '0;
      t0_r       <= '0;
      edge_idx_r <= 2'd0;
    end else begin
      case (state_r)
        ST_WAIT_IDLE: begin
          if (sync_s) idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
          else        idle_cnt_r <= '0;
        end
        ST_WAIT_START: begin
          idle_cnt_r <= '0;
          if (fall_s) begin
            int_cnt_r  <= CNT_ONE;
            total_r    <= CNT_ONE;
            edge_idx_r <= 2'd0;
          end
        end
        ST_MEASURE: begin
          idle_cnt_r <= '0;
          if (fall_s) begin
            int_cnt_r  <= CNT_ONE;
            edge_idx_r <= edge_idx_r + 2'd1;
            if (edge_idx_r == 2'd0) t0_r <= int_cnt_r;
          end else if (int_cnt_r != CNT_MAX) begin
            int_cnt_r <= int_cnt_r + CNT_ONE;
          end
          if (!final_edge_s && (total_r != CNT_MAX)) total_r <= total_r + CNT_ONE;
        end
        default: idle_cnt_r <= '0;
      endcase
    end
  end

  // Registered outputs; a failed retry leaves the previous prescale/lock untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_r <= DEFAULT_PRESCALE;
      locked_r   <= 1'b0;
      busy_r     <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      busy_r  <= (state_s != ST_IDLE);
      error_r <= (state_s == ST_ERROR);
      if (arm) begin
        locked_r <= 1'b0;
      end else if (commit_s) begin
        prescale_r <= p_s[15:0];
        locked_r   <= 1'b1;
      end
    end
  end

  assign prescale = prescale_r;
  assign locked   = locked_r;
  assign busy     = busy_r;
  assign error    = error_r;

endmodule
